// File: rtl/uart_rx_nbyte_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_nbyte_param : parametrised burst UART receiver             rev 1.0
// ---------------------------------------------------------------------------
module uart_rx_nbyte_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 2,
  parameter int MSB_FIRST    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int CNT_WIDTH    = 10
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [CNT_WIDTH-1:0] bytes_to_rx,
  input  logic                 serial_data_in,
  output logic                 rx_data_valid,
  output logic [DATA_BITS-1:0] rx_data_byte,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy,
  output logic                 rx_burst_done
);

  localparam int c_CLK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_BIT_W = $clog2(DATA_BITS);

  localparam logic [c_CLK_W-1:0]   c_LAST_CLK = c_CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CLK_W-1:0]   c_CLK_ONE  = c_CLK_W'(1);
  localparam logic [c_BIT_W-1:0]   c_LAST_BIT = c_BIT_W'(DATA_BITS - 1);
  localparam logic [c_BIT_W-1:0]   c_BIT_ONE  = c_BIT_W'(1);
  localparam logic [CNT_WIDTH-1:0] c_REM_ONE  = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    STRT = 3'd1,
    DATA = 3'd2,
    PAR  = 3'd3,
    STOP = 3'd4
  } state_e;

  state_e                 state_q,   state_d;
  logic [c_CLK_W-1:0]     clk_ctr_q, clk_ctr_d;
  logic [c_BIT_W-1:0]     bit_ctr_q, bit_ctr_d;
  logic [CNT_WIDTH-1:0]   rem_ctr_q, rem_ctr_d;
  logic [DATA_BITS-1:0]   shreg_q,   shreg_d;
  logic                   par_err_q, par_err_d;
  logic                   valid_q,   valid_d;
  logic                   done_q,    done_d;
  logic [DATA_BITS-1:0]   data_q,    data_d;
  logic                   perr_q,    perr_d;
  logic                   ferr_q,    ferr_d;

  logic                   w_sample;
  logic                   w_par_err;
  logic [DATA_BITS-1:0]   w_shreg_next;

  assign w_sample  = (clk_ctr_q == c_LAST_CLK);
  assign w_par_err = ((^shreg_q) ^ serial_data_in) != (PARITY_ODD != 0);

  // Shifting toward the far end leaves the first received bit in the slot
  // that the chosen bit order assigns to it once all DATA_BITS have arrived.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shreg_next = {shreg_q[DATA_BITS-2:0], serial_data_in};
    end else begin : g_lsb_first
      assign w_shreg_next = {serial_data_in, shreg_q[DATA_BITS-1:1]};
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      clk_ctr_q <= '0;
      bit_ctr_q <= '0;
      rem_ctr_q <= '0;
      shreg_q   <= '0;
      par_err_q <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_ctr_q <= clk_ctr_d;
      bit_ctr_q <= bit_ctr_d;
      rem_ctr_q <= rem_ctr_d;
      shreg_q   <= shreg_d;
      par_err_q <= par_err_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_ctr_d = clk_ctr_q;
    bit_ctr_d = bit_ctr_q;
    rem_ctr_d = rem_ctr_q;
    shreg_d   = shreg_q;
    par_err_d = par_err_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    data_d    = data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;

    if (state_q != IDLE) begin
      clk_ctr_d = w_sample ? '0 : clk_ctr_q + c_CLK_ONE;
    end

    case (state_q)
      IDLE: begin
        rem_ctr_d = bytes_to_rx;
        clk_ctr_d = '0;
        bit_ctr_d = '0;
        if (!serial_data_in) begin
          state_d = STRT;
        end
      end
      STRT: begin
        if (w_sample) begin
          bit_ctr_d = '0;
          state_d   = serial_data_in ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_sample) begin
          shreg_d = w_shreg_next;
          if (bit_ctr_q == c_LAST_BIT) begin
            bit_ctr_d = '0;
            state_d   = (PARITY_EN != 0) ? PAR : STOP;
          end else begin
            bit_ctr_d = bit_ctr_q + c_BIT_ONE;
          end
        end
      end
      PAR: begin
        if (w_sample) begin
          par_err_d = w_par_err;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (w_sample) begin
          valid_d = 1'b1;
          data_d  = shreg_q;
          perr_d  = (PARITY_EN != 0) ? par_err_q : 1'b0;
          ferr_d  = ~serial_data_in;
          // A broken stop bit abandons whatever is left of the burst.
          if (!serial_data_in || (rem_ctr_q == '0)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rem_ctr_d = rem_ctr_q - c_REM_ONE;
            state_d   = STRT;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_data_valid = valid_q;
  assign rx_data_byte  = data_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;
  assign rx_burst_done = done_q;
  assign rx_busy       = (state_q != IDLE);

endmodule
`default_nettype wire
